// File: rtl/pkt_tx_arbiter.sv
// Merges peripheral and diagnostic packet streams onto one transmit port
// through a 2-entry FIFO, with round-robin or diagnostic-priority arbitration.
`ifndef PKT_BITS
`define PKT_BITS 72
`endif

module pkt_tx_arbiter #(
  parameter int PACKET_BITS = `PKT_BITS,
  parameter int FAIR_LIMIT  = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PACKET_BITS-1:0] per_data_in,
  input  logic                   per_vld_in,
  output logic                   per_rdy_out,
  input  logic [PACKET_BITS-1:0] dcp_data_in,
  input  logic                   dcp_vld_in,
  output logic                   dcp_rdy_out,
  output logic [PACKET_BITS-1:0] pkt_data_out,
  output logic                   pkt_vld_out,
  input  logic                   pkt_rdy_in,
  input  logic                   prio_in,
  output logic [1:0]             ptx_cnt_out
);

  localparam logic       GRANT_PER    = 1'b0;
  localparam logic       GRANT_DCP    = 1'b1;
  localparam logic [3:0] STREAK_MAX   = 4'hF;
  localparam logic [3:0] FAIR_LIMIT_V = 4'(FAIR_LIMIT);

  logic [1:0]             occ_r;
  logic [PACKET_BITS-1:0] head_r;
  logic [PACKET_BITS-1:0] tail_r;
  logic                   vld_r;
  logic                   last_grant_r;
  logic [3:0]             streak_r;

  logic                   grant_per_s;
  logic                   grant_dcp_s;
  logic                   per_hs_s;
  logic                   dcp_hs_s;
  logic                   in_hs_s;
  logic                   out_hs_s;
  logic [1:0]             occ_next_s;
  logic [PACKET_BITS-1:0] in_data_s;

  // Grant selection; nothing is granted while full or while in reset.
  always_comb begin
    grant_per_s = 1'b0;
    grant_dcp_s = 1'b0;
    if (reset || (occ_r == 2'd2)) begin
      grant_per_s = 1'b0;
      grant_dcp_s = 1'b0;
    end else begin
      case ({per_vld_in, dcp_vld_in})
        2'b10: grant_per_s = 1'b1;
        2'b01: grant_dcp_s = 1'b1;
        2'b11: begin
          if (prio_in) begin
            if (streak_r == FAIR_LIMIT_V) begin
              grant_per_s = 1'b1;
            end else begin
              grant_dcp_s = 1'b1;
            end
          end else begin
            if (last_grant_r == GRANT_DCP) begin
              grant_per_s = 1'b1;
            end else begin
              grant_dcp_s = 1'b1;
            end
          end
        end
        default: begin
          grant_per_s = 1'b0;
          grant_dcp_s = 1'b0;
        end
      endcase
    end
  end

  assign per_hs_s     = per_vld_in && grant_per_s;
  assign dcp_hs_s     = dcp_vld_in && grant_dcp_s;
  assign in_hs_s      = per_hs_s || dcp_hs_s;
  assign out_hs_s     = vld_r && pkt_rdy_in;
  assign in_data_s    = grant_dcp_s ? dcp_data_in : per_data_in;
  assign per_rdy_out  = grant_per_s;
  assign dcp_rdy_out  = grant_dcp_s;
  assign ptx_cnt_out  = {dcp_hs_s, per_hs_s};
  assign pkt_data_out = head_r;
  assign pkt_vld_out  = vld_r;

  // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    occ_next_s = occ_r;
    case ({in_hs_s, out_hs_s})
      2'b10:   occ_next_s = occ_r + 2'd1;
      2'b01:   occ_next_s = occ_r - 2'd1;
      default: occ_next_s = occ_r;
    endcase
  end

  // FIFO storage: head_r is the output register, tail_r the second slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_r  <= 2'd0;
      vld_r  <= 1'b0;
      head_r <= '0;
      tail_r <= '0;
    end else begin
      occ_r <= occ_next_s;
      vld_r <= (occ_next_s != 2'd0);
      if (in_hs_s && ((occ_r == 2'd0) || ((occ_r == 2'd1) && out_hs_s))) begin
        head_r <= in_data_s;
      end else if (out_hs_s && (occ_r == 2'd2)) begin
        head_r <= tail_r;
      end else begin
        head_r <= head_r;
      end
      if (in_hs_s && (occ_r == 2'd1) && !out_hs_s) begin
        tail_r <= in_data_s;
      end else begin
        tail_r <= tail_r;
      end
    end
  end

  // Arbiter history: last winner and the diagnostic-priority streak.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r <= GRANT_PER;
      streak_r     <= 4'd0;
    end else begin
      if (per_hs_s) begin
        last_grant_r <= GRANT_PER;
      end else if (dcp_hs_s) begin
        last_grant_r <= GRANT_DCP;
      end else begin
        last_grant_r <= last_grant_r;
      end
      if (!prio_in || per_hs_s) begin
        streak_r <= 4'd0;
      end else if (dcp_hs_s && per_vld_in && (streak_r != STREAK_MAX)) begin
        streak_r <= streak_r + 4'd1;
      end else begin
        streak_r <= streak_r;
      end
    end
  end

endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// Self-checking bench for pkt_tx_arbiter: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_pkt_tx_arbiter;

  localparam int W  = 72;
  localparam int FL = 15;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] per_data_in = '0;
  logic         per_vld_in = 1'b0;
  logic         per_rdy_out;
  logic [W-1:0] dcp_data_in = '0;
  logic         dcp_vld_in = 1'b0;
  logic         dcp_rdy_out;
  logic [W-1:0] pkt_data_out;
  logic         pkt_vld_out;
  logic         pkt_rdy_in = 1'b0;
  logic         prio_in = 1'b0;
  logic [1:0]   ptx_cnt_out;

  pkt_tx_arbiter #(.PACKET_BITS(W), .FAIR_LIMIT(FL)) dut (
    .clk(clk), .reset(reset),
    .per_data_in(per_data_in), .per_vld_in(per_vld_in), .per_rdy_out(per_rdy_out),
    .dcp_data_in(dcp_data_in), .dcp_vld_in(dcp_vld_in), .dcp_rdy_out(dcp_rdy_out),
    .pkt_data_out(pkt_data_out), .pkt_vld_out(pkt_vld_out), .pkt_rdy_in(pkt_rdy_in),
    .prio_in(prio_in), .ptx_cnt_out(ptx_cnt_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // Reference model: packets waiting for the transceiver, plus arbiter history.
  logic [W-1:0] mq[$];
  bit           m_last_dcp;
  int           m_streak;

  logic         obs_prdy, obs_drdy, obs_vld;
  logic [W-1:0] obs_data;

  typedef struct packed {
    logic pv, dv, prio, ordy, e_prdy, e_drdy, e_vld;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_grant(input logic pv, input logic dv, input logic pr,
                                      output bit gp, output bit gd);
    gp = 1'b0;
    gd = 1'b0;
    if (mq.size() < 2) begin
      if (pv && dv) begin
        if (pr) begin
          if (m_streak == FL) gp = 1'b1; else gd = 1'b1;
        end else begin
          if (m_last_dcp) gp = 1'b1; else gd = 1'b1;
        end
      end else begin
        gp = pv;
        gd = dv;
      end
    end
  endfunction

  function automatic void model_clear();
    mq.delete();
    m_last_dcp = 1'b0;
    m_streak   = 0;
  endfunction

  // One clock cycle: apply inputs, check all outputs mid-cycle, advance model.
  task automatic cycle(input logic pv, input logic [W-1:0] pd, input logic dv,
                       input logic [W-1:0] dd, input logic pr, input logic ordy);
    bit gp, gd, ohs;
    per_vld_in = pv; per_data_in = pd;
    dcp_vld_in = dv; dcp_data_in = dd;
    prio_in = pr; pkt_rdy_in = ordy;
    model_grant(pv, dv, pr, gp, gd);
    #4;
    obs_prdy = per_rdy_out; obs_drdy = dcp_rdy_out;
    obs_vld = pkt_vld_out; obs_data = pkt_data_out;
    chk("per_rdy", W'(per_rdy_out), W'(gp));
    chk("dcp_rdy", W'(dcp_rdy_out), W'(gd));
    chk("ptx_cnt", W'(ptx_cnt_out), W'({gd, gp}));
    chk("pkt_vld", W'(pkt_vld_out), W'(mq.size() != 0));
    if (mq.size() != 0) chk("pkt_data", pkt_data_out, mq[0]);
    ohs = (mq.size() != 0) && ordy;
    @(posedge clk);
    if (ohs) void'(mq.pop_front());
    if (gp) mq.push_back(pd);
    if (gd) mq.push_back(dd);
    if (gp) m_last_dcp = 1'b0;
    if (gd) m_last_dcp = 1'b1;
    if (!pr || gp) m_streak = 0;
    else if (gd && pv && m_streak < 15) m_streak++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    per_vld_in = 1'b1; dcp_vld_in = 1'b1; pkt_rdy_in = 1'b1;
    #1;
    chk("rst_per_rdy", W'(per_rdy_out), W'(0));
    chk("rst_dcp_rdy", W'(dcp_rdy_out), W'(0));
    chk("rst_ptx_cnt", W'(ptx_cnt_out), W'(0));
    chk("rst_vld", W'(pkt_vld_out), W'(0));
    chk("rst_data", pkt_data_out, W'(0));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    per_vld_in = 1'b0; dcp_vld_in = 1'b0;
    model_clear();
  endtask

  function automatic logic [W-1:0] rnd72();
    return {8'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  initial begin
    logic [W-1:0] pk, p0, p1, p2;
    // pv dv prio ordy | e_prdy e_drdy e_vld
    tbl[0]  = 7'b0001_000;
    tbl[1]  = 7'b1001_100;
    tbl[2]  = 7'b1101_011;
    tbl[3]  = 7'b1101_101;
    tbl[4]  = 7'b1100_011;
    tbl[5]  = 7'b1100_001;
    tbl[6]  = 7'b0001_001;
    tbl[7]  = 7'b0001_001;
    tbl[8]  = 7'b0001_000;
    tbl[9]  = 7'b1111_010;
    tbl[10] = 7'b1111_011;
    tbl[11] = 7'b1001_101;
    tbl[12] = 7'b0101_011;
    tbl[13] = 7'b0001_001;
    tbl[14] = 7'b0001_000;

    model_clear();
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].pv, {8'h5A, 64'(i)}, tbl[i].dv, {8'hDC, 64'(i)}, tbl[i].prio, tbl[i].ordy);
      chk($sformatf("tbl%0d_prdy", i), W'(obs_prdy), W'(tbl[i].e_prdy));
      chk($sformatf("tbl%0d_drdy", i), W'(obs_drdy), W'(tbl[i].e_drdy));
      chk($sformatf("tbl%0d_vld", i),  W'(obs_vld),  W'(tbl[i].e_vld));
    end

    // Round-robin with both sources valid: D,P,D,P... one per cycle.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      cycle(k < 8, {8'h50, 64'(k)}, k < 8, {8'hD0, 64'(k)}, 1'b0, 1'b1);
      if (k >= 1) begin
        chk("rr_vld", W'(obs_vld), W'(1));
        chk("rr_order", obs_data, ((k - 1) % 2 == 0) ? {8'hD0, 64'(k - 1)} : {8'h50, 64'(k - 1)});
      end
    end

    // Single peripheral packet: one-cycle latency, bit-exact.
    pk = 72'hAA_11223344_55667755;
    cycle(1'b1, pk, 1'b0, '0, 1'b0, 1'b1);
    chk("single_acc", W'(obs_prdy), W'(1));
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    chk("single_out", obs_data, pk);
    chk("single_vld", W'(obs_vld), W'(1));
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    chk("single_gone", W'(obs_vld), W'(0));

    // Priority mode fairness: 15 D then 1 P; dropping prio restores alternation.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      cycle(1'b1, rnd72(), 1'b1, rnd72(), k < 37, 1'b1);
      if (k < 37) chk("prio_pattern", W'(obs_drdy), W'((k % 16) != 15));
      else chk("prio_off_alt", W'(obs_prdy), W'((k % 2) == 1));
    end

    // Backpressure with three offered packets.
    do_reset();
    p0 = rnd72(); p1 = rnd72(); p2 = rnd72();
    cycle(1'b1, p0, 1'b0, '0, 1'b0, 1'b0); chk("bp_acc0", W'(obs_prdy), W'(1));
    cycle(1'b1, p1, 1'b0, '0, 1'b0, 1'b0); chk("bp_acc1", W'(obs_prdy), W'(1));
    cycle(1'b1, p2, 1'b1, p2, 1'b0, 1'b0);
    chk("bp_full_p", W'(obs_prdy), W'(0));
    chk("bp_full_d", W'(obs_drdy), W'(0));
    chk("bp_head", obs_data, p0);
    cycle(1'b1, p2, 1'b0, '0, 1'b0, 1'b1);
    chk("bp_drain0", obs_data, p0); chk("bp_wait", W'(obs_prdy), W'(0));
    cycle(1'b1, p2, 1'b0, '0, 1'b0, 1'b1);
    chk("bp_drain1", obs_data, p1); chk("bp_acc2", W'(obs_prdy), W'(1));
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    chk("bp_drain2", obs_data, p2);

    // Simultaneous push and pop at occupancy 1: no bubbles.
    do_reset();
    for (int k = 0; k < 11; k++) begin
      cycle(1'b1, rnd72(), 1'b0, '0, 1'b0, 1'b1);
      if (k >= 1) begin
        chk("steady_vld", W'(obs_vld), W'(1));
        chk("steady_rdy", W'(obs_prdy), W'(1));
      end
    end

    // Reset while full: output drops at once and nothing is replayed.
    cycle(1'b1, rnd72(), 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, rnd72(), 1'b0, '0, 1'b0, 1'b0);
    chk("full_before_rst", W'(pkt_vld_out), W'(1));
    reset = 1'b1;
    #1;
    chk("async_rst_vld", W'(pkt_vld_out), W'(0));
    chk("async_rst_data", pkt_data_out, W'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      chk("no_replay", W'(obs_vld), W'(0));
    end

    // Random traffic against the model, with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle(1'($urandom_range(0, 3) != 0), rnd72(), 1'($urandom_range(0, 3) != 0), rnd72(),
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
